// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and width helpers for the FIFO write arbiter.
//                - arb_state_t : arbiter FSM states (IDLE, BURST)
//                - owner_w()   : width of a requester index
//                - cnt_w()     : width of the per-grant word counter
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width for NUM_REQ requesters (never zero).
    function automatic int owner_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Counter must be able to hold MAX_BURST-1; one spare code keeps the
    // MAX_BURST = 1 case at a legal 1-bit width.
    function automatic int cnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst + 1) : 1;
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin search. Returns the first set bit
//                of i_req looking at i_ptr, i_ptr+1, ... modulo NUM_REQ.
//  Ports       : i_req   [NUM_REQ-1:0] request vector
//                i_ptr   [IDX_W-1:0]   search start position (< NUM_REQ)
//                o_valid               at least one request is set
//                o_idx   [IDX_W-1:0]   index of the selected request
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [IDX_W:0]   w_pos;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // One extra bit so ptr + i never overflows before the modulo.
            w_pos = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
            end
            w_cand = w_pos[IDX_W-1:0];
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin, burst-granting write arbiter in front of a
//                sync_fifo write port. Never writes into a full FIFO.
//  Ports       : clk              clock
//                rst_n            asynchronous reset, asserted HIGH
//                req_i            per-producer word available
//                data_i           packed producer words, k at [k*DW +: DW]
//                last_i           current word ends the producer's packet
//                gnt_o            one-hot, word accepted this cycle (comb.)
//                fifo_wr_en_o     registered FIFO write strobe
//                fifo_wr_data_o   registered FIFO write data
//                fifo_elem_cnt_i  FIFO occupancy
//                owner_o          current burst owner
//                busy_o           arbiter is in a burst
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int DATA_DEPTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int OWNER_W    = owner_w(NUM_REQ),
    localparam int CNT_W      = cnt_w(MAX_BURST),
    localparam int ELEM_W     = $clog2(DATA_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    input  logic [NUM_REQ-1:0]            last_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    input  logic [ELEM_W-1:0]             fifo_elem_cnt_i,
    output logic [OWNER_W-1:0]            owner_o,
    output logic                          busy_o
);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [OWNER_W-1:0]      r_rr_ptr;
    logic [OWNER_W-1:0]      w_rr_ptr_nxt;
    logic [OWNER_W-1:0]      r_owner;
    logic [OWNER_W-1:0]      w_owner_nxt;
    logic [CNT_W-1:0]        r_burst_cnt;
    logic [CNT_W-1:0]        w_burst_cnt_nxt;
    logic                    r_wr_en;
    logic [DATA_WIDTH-1:0]   r_wr_data;

    logic                    w_pick_valid;
    logic [OWNER_W-1:0]      w_pick_idx;
    logic [ELEM_W:0]         w_occupancy;
    logic                    w_space;
    logic                    w_owner_req;
    logic                    w_owner_last;
    logic [DATA_WIDTH-1:0]   w_owner_data;
    logic [OWNER_W-1:0]      w_owner_inc;
    logic                    w_accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWNER_W)
    ) u_rr_pick (
        .i_req   (req_i),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // The FIFO count lags the write strobe by one cycle, so the word already
    // in flight is added. Reads are ignored, which only ever under-fills.
    assign w_occupancy = {1'b0, fifo_elem_cnt_i} + {{ELEM_W{1'b0}}, r_wr_en};
    assign w_space     = (w_occupancy < (ELEM_W+1)'(DATA_DEPTH));

    assign w_owner_req  = req_i[r_owner];
    assign w_owner_last = last_i[r_owner];
    assign w_owner_data = data_i[r_owner*DATA_WIDTH +: DATA_WIDTH];
    assign w_owner_inc  = (r_owner == OWNER_W'(NUM_REQ-1)) ? '0 : r_owner + OWNER_W'(1);

    // Next-state and grant logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        w_accept        = 1'b0;
        gnt_o           = '0;
        busy_o          = 1'b0;
        case (r_state)
            IDLE: begin
                // Arbitration takes a full cycle; nothing is accepted here.
                if (w_pick_valid) begin
                    w_owner_nxt     = w_pick_idx;
                    w_burst_cnt_nxt = '0;
                    w_state_nxt     = BURST;
                end
            end
            BURST: begin
                busy_o         = 1'b1;
                w_accept       = w_owner_req & w_space;
                gnt_o[r_owner] = w_accept;
                if (!w_owner_req) begin
                    // Producer walked away mid-packet: give up the grant.
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_owner_inc;
                end else if (w_accept) begin
                    if (w_owner_last || (r_burst_cnt == CNT_W'(MAX_BURST-1))) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = w_owner_inc;
                    end else begin
                        w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
                    end
                end
                // A stall (owner requesting, no space) holds everything.
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
        end else begin
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_wr_en     <= w_accept;
            if (w_accept) begin
                r_wr_data <= w_owner_data;
            end
        end
    end

    assign fifo_wr_en_o   = r_wr_en;
    assign fifo_wr_data_o = r_wr_data;
    assign owner_o        = r_owner;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter. Producers are
//                modelled as word queues, the FIFO as a behavioural queue
//                whose count lags the write strobe by one cycle. Expected
//                FIFO writes are queued when stimulus is loaded and compared
//                as each write strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DW        = 32;
    localparam int DEPTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int CW        = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } pw_t;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_i;
    logic [NUM_REQ*DW-1:0]   data_i;
    logic [NUM_REQ-1:0]      last_i;
    logic [NUM_REQ-1:0]      gnt_o;
    logic                    fifo_wr_en_o;
    logic [DW-1:0]           fifo_wr_data_o;
    logic [CW-1:0]           fifo_cnt;
    logic [1:0]              owner_o;
    logic                    busy_o;

    pw_t                     pq [NUM_REQ][$];
    logic [NUM_REQ-1:0]      drv_en;
    logic [DW-1:0]           exp_q [$];
    logic [NUM_REQ-1:0]      gnt_log [$];
    logic [DW-1:0]           fifo_q [$];
    logic [DW-1:0]           rd_log [$];
    logic                    fifo_rd;
    logic                    fifo_flush;
    int                      wr_count;
    int                      n_vec;
    int                      n_err;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_i           (req_i),
        .data_i          (data_i),
        .last_i          (last_i),
        .gnt_o           (gnt_o),
        .fifo_wr_en_o    (fifo_wr_en_o),
        .fifo_wr_data_o  (fifo_wr_data_o),
        .fifo_elem_cnt_i (fifo_cnt),
        .owner_o         (owner_o),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sync_fifo: read before write, count visible next cycle.
    always @(posedge clk) begin
        if (fifo_flush) begin
            fifo_q.delete();
        end else begin
            if (fifo_rd && fifo_q.size() != 0) rd_log.push_back(fifo_q.pop_front());
            if (fifo_wr_en_o && fifo_q.size() < DEPTH) fifo_q.push_back(fifo_wr_data_o);
        end
        fifo_cnt <= CW'(fifo_q.size());
    end

    function automatic void drive_inputs();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_i[k]          = drv_en[k] && (pq[k].size() != 0);
            data_i[k*DW +: DW] = (pq[k].size() != 0) ? pq[k][0].d : '0;
            last_i[k]         = (pq[k].size() != 0) ? pq[k][0].last : 1'b0;
        end
    endfunction

    function automatic void load_pkt(input int k, input int first, input int len);
        for (int n = 0; n < len; n++) pq[k].push_back('{d: DW'(first + n), last: (n == len - 1)});
    endfunction

    function automatic void push_exp(input int first, input int len);
        for (int n = 0; n < len; n++) exp_q.push_back(DW'(first + n));
    endfunction

    // One clock: sample at negedge (scoreboard + grant), advance producers
    // just after the posedge.
    task automatic tick();
        logic [NUM_REQ-1:0] g;
        logic [DW-1:0]      e;
        @(negedge clk);
        gnt_log.push_back(gnt_o);
        if (fifo_wr_en_o === 1'b1) begin
            wr_count++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_write: got unexpected write data %0d, expected no write", fifo_wr_data_o);
            end else begin
                e = exp_q.pop_front();
                if (fifo_wr_data_o !== e) begin
                    n_err++;
                    $display("FAIL sb_write: got data %0d, expected %0d", fifo_wr_data_o, e);
                end
            end
            n_vec++;
            if (fifo_cnt >= CW'(DEPTH)) begin
                n_err++;
                $display("FAIL no_overflow: write issued with elem_cnt %0d, expected < %0d", fifo_cnt, DEPTH);
            end
        end
        g = gnt_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (g[k] && pq[k].size() != 0) void'(pq[k].pop_front());
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n      = 1'b1;
        fifo_flush = 1'b1;
        fifo_rd    = 1'b0;
        drv_en     = '1;
        for (int k = 0; k < NUM_REQ; k++) pq[k].delete();
        drive_inputs();
        repeat (2) tick();
        rst_n      = 1'b0;
        fifo_flush = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) rst_n = 1'b0;
            tick();
            n_vec++;
            if ({fifo_wr_en_o, gnt_o, busy_o, owner_o} !== '0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got wr_en=%b gnt=%b busy=%b owner=%0d, expected all 0",
                         c, fifo_wr_en_o, gnt_o, busy_o, owner_o);
            end
        end
    endtask

    task automatic test_single();
        logic [NUM_REQ-1:0] exp_g [6];
        exp_g = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        gnt_log.delete();
        pq[1].push_back('{d: 32'd5, last: 1'b0});
        pq[1].push_back('{d: 32'd6, last: 1'b0});
        pq[1].push_back('{d: 32'd7, last: 1'b1});
        push_exp(5, 3);
        drive_inputs();
        repeat (6) tick();
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (gnt_log[i] !== exp_g[i]) begin
                n_err++;
                $display("FAIL single_gnt[%0d]: got %b, expected %b", i, gnt_log[i], exp_g[i]);
            end
        end
        n_vec++;
        if (fifo_cnt !== 4'd3 || fifo_q.size() != 3 || fifo_q[0] !== 32'd5 || fifo_q[2] !== 32'd7) begin
            n_err++;
            $display("FAIL single_fifo: got cnt %0d size %0d, expected cnt 3 holding 5,6,7", fifo_cnt, fifo_q.size());
        end
        // rr_ptr now 2: producer 2 must beat producer 0.
        pq[0].push_back('{d: 32'd10, last: 1'b1});
        pq[2].push_back('{d: 32'd20, last: 1'b1});
        exp_q.push_back(32'd20);
        exp_q.push_back(32'd10);
        drive_inputs();
        for (int n = 0; n < 30 && exp_q.size() != 0; n++) tick();
        repeat (2) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL single_rrptr: got %0d writes outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_fairness();
        do_reset();
        fifo_rd = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) begin
            load_pkt(k, 16*k, 2);
            load_pkt(k, 16*k + 2, 2);
        end
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_REQ; k++) push_exp(16*k + 2*r, 2);
        drive_inputs();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
        repeat (3) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fairness_done: got %0d writes outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_forced_rotation();
        do_reset();
        fifo_rd = 1'b1;
        load_pkt(0, 100, 6);
        load_pkt(2, 200, 2);
        push_exp(100, 4);
        push_exp(200, 2);
        push_exp(104, 2);
        drive_inputs();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
        repeat (3) tick();
        n_vec++;
        if (exp_q.size() != 0 || pq[0].size() != 0) begin
            n_err++;
            $display("FAIL rotation_done: got %0d outstanding, p0 left %0d, expected 0 and 0", exp_q.size(), pq[0].size());
        end
    endtask

    task automatic test_full_throttle();
        int wr0;
        do_reset();
        wr0 = wr_count;
        load_pkt(3, 300, 10);
        push_exp(300, 8);
        drive_inputs();
        repeat (30) tick();
        gnt_log.delete();
        repeat (10) tick();
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (gnt_log[i][3] !== 1'b0) begin
                n_err++;
                $display("FAIL full_gnt[%0d]: got gnt %b with FIFO full, expected bit3 = 0", i, gnt_log[i]);
            end
        end
        n_vec++;
        if (wr_count - wr0 != 8 || fifo_cnt !== 4'd8 || pq[3].size() != 2) begin
            n_err++;
            $display("FAIL full_count: got %0d writes cnt %0d left %0d, expected 8 writes cnt 8 left 2",
                     wr_count - wr0, fifo_cnt, pq[3].size());
        end
        push_exp(308, 1);
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        repeat (15) tick();
        n_vec++;
        if (wr_count - wr0 != 9 || fifo_cnt !== 4'd8 || pq[3].size() != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL full_refill: got %0d writes cnt %0d left %0d, expected 9 writes cnt 8 left 1",
                     wr_count - wr0, fifo_cnt, pq[3].size());
        end
        n_vec++;
        if (rd_log[rd_log.size()-1] !== 32'd300) begin
            n_err++;
            $display("FAIL full_pop: got %0d, expected 300", rd_log[rd_log.size()-1]);
        end
    endtask

    task automatic test_abort();
        do_reset();
        fifo_rd = 1'b1;
        load_pkt(1, 400, 4);
        push_exp(400, 2);
        drive_inputs();
        for (int n = 0; n < 20 && pq[1].size() > 2; n++) tick();
        n_vec++;
        if (pq[1].size() != 2) begin
            n_err++;
            $display("FAIL abort_setup: got %0d words left, expected 2", pq[1].size());
        end
        drv_en[1] = 1'b0;
        drive_inputs();
        gnt_log.delete();
        tick();
        n_vec++;
        if (busy_o !== 1'b0 || gnt_log[0] !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_idle: got busy %b gnt %b, expected busy 0 gnt 0000", busy_o, gnt_log[0]);
        end
        // rr_ptr now 2: producer 2 goes before producer 1 resumes.
        load_pkt(2, 500, 1);
        push_exp(500, 1);
        push_exp(402, 2);
        drv_en[1] = 1'b1;
        drive_inputs();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
        repeat (2) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL abort_resume: got %0d writes outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load_pkt(0, 600, 4);
        drive_inputs();
        for (int n = 0; n < 20 && pq[0].size() > 3; n++) tick();
        n_vec++;
        if (fifo_wr_en_o !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: got wr_en %b, expected 1", fifo_wr_en_o);
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({fifo_wr_en_o, busy_o, gnt_o, owner_o} !== '0) begin
            n_err++;
            $display("FAIL midrst_async: got wr_en=%b busy=%b gnt=%b owner=%0d, expected all 0",
                     fifo_wr_en_o, busy_o, gnt_o, owner_o);
        end
        pq[0].delete();
        drive_inputs();
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        n_vec++;
        if (fifo_q.size() != 0 || fifo_cnt !== '0) begin
            n_err++;
            $display("FAIL midrst_drop: got FIFO size %0d cnt %0d, expected 0 and 0", fifo_q.size(), fifo_cnt);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        wr_count   = 0;
        rst_n      = 1'b1;
        req_i      = '0;
        data_i     = '0;
        last_i     = '0;
        drv_en     = '1;
        fifo_rd    = 1'b0;
        fifo_flush = 1'b1;
        test_reset();
        test_single();
        test_fairness();
        test_forced_rotation();
        test_full_throttle();
        test_abort();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ producers.
- Grants bursts (packets) to one requester at a time and drives the FIFO write strobe and data.
- Throttles on FIFO occupancy so no write is ever issued into a full FIFO.
- Sits directly in front of sync_fifo wr_en_i/wr_data_i; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (≥2).
- DATA_WIDTH, 32, word width; must match the FIFO.
- DATA_DEPTH, 8, FIFO depth; must match the FIFO.
- MAX_BURST, 4, maximum words per grant before forced rotation (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high. Reset is asserted while rst_n = 1.
- req_i  in  NUM_REQ  per-producer "word available".
- data_i  in  NUM_REQ*DATA_WIDTH  packed words; producer k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- last_i  in  NUM_REQ  current word is the final word of the producer's packet.
- gnt_o  out  NUM_REQ  combinational one-hot; the word is accepted this cycle.
- fifo_wr_en_o  out  1  registered write strobe to the FIFO.
- fifo_wr_data_o  out  DATA_WIDTH  registered write data.
- fifo_elem_cnt_i  in  $clog2(DATA_DEPTH)+1  FIFO occupancy.
- owner_o  out  $clog2(NUM_REQ)  current burst owner.
- busy_o  out  1  high in state BURST.

Behaviour:
- Reset values: state = IDLE, rr_ptr = 0, owner_o = 0, burst_cnt = 0, fifo_wr_en_o = 0, fifo_wr_data_o = 0, gnt_o = 0, busy_o = 0.
- FSM states are IDLE and BURST.
- IDLE:
  - If any req_i is set, select the first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Register it into owner_o, clear burst_cnt, and go to BURST next cycle.
  - No word is accepted in IDLE, so arbitration costs 1 cycle.
- space = (fifo_elem_cnt_i + fifo_wr_en_o) < DATA_DEPTH.
  - The in-flight write is counted because the FIFO updates its count the cycle after wr_en.
  - Concurrent reads are ignored, which is conservative.
  - Compute the sum one bit wider to avoid overflow.
- BURST, acceptance:
  - gnt_o[owner] = req_i[owner] & space.
  - On accept, next cycle fifo_wr_en_o = 1 and fifo_wr_data_o = data_i[owner]. Otherwise fifo_wr_en_o = 0 and the data holds its previous value.
  - Latency from accept to FIFO write strobe: 1 cycle.
- BURST, exit to IDLE with rr_ptr = owner+1 mod NUM_REQ when any of the following occurs:
  - an accepted word has last_i[owner] = 1;
  - the accepted word makes burst_cnt reach MAX_BURST (forced rotation);
  - req_i[owner] = 0 (producer abandoned).
- In BURST with no exit condition, burst_cnt increments per accepted word.
- Stall: when space = 0 while the owner requests, hold the grant. burst_cnt is unchanged and ownership is not lost to stalls.
- Non-owner requests are ignored during BURST and gnt_o is 0 for them.
- Producers must hold data_i and last_i stable while req_i is high and not yet granted.
- MAX_BURST = 1 gives per-word round-robin. Back-to-back packets therefore have a 1-cycle IDLE gap.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-burst: all state returns to reset values immediately and asynchronously; a partial packet is dropped with no write strobe. FIFO contents are the FIFO's own concern.
- fifo_wr_en_o is never asserted when the post-write count would exceed DATA_DEPTH.

Decomposition:
- Shared package fifo_arb_pkg:
  - FSM state enum (IDLE, BURST);
  - function clog2-based width constants (OWNER_W, CNT_W).
- One sub-module, rr_pick:
  - combinational priority search from a rotating pointer;
  - inputs req vector and ptr; outputs valid and index.
- Bench instantiates fifo_wr_arbiter + sync_fifo back-to-back.

Test Plan:
- Reset and idle: rst_n = 1 for 2 cycles, then 0, with no req → fifo_wr_en_o, gnt_o, busy_o stay 0 and owner_o = 0.
- Single packet: req_i = 4'b0010 with words 5, 6, 7, last on 7 → gnt_o[1] on 3 consecutive cycles starting 1 cycle after req. FIFO receives 5, 6, 7 and elem_cnt = 3. Back in IDLE, rr_ptr = 2.
- Fairness: all 4 request continuous 2-word packets (data = 16*k + n) → FIFO order is producers 0, 1, 2, 3, 0. With reads draining, no producer waits more than 3 bursts.
- Forced rotation: producer 0 sends a 6-word packet with MAX_BURST = 4 while producer 2 requests → words 0..3 from p0, then p2's packet, then p0's remaining 2 words.
- Full throttle: no reads, producer 3 pushes 10 words → exactly 8 writes. gnt_o[3] stays 0 while elem_cnt = 8. After popping 1 word, exactly one more write is issued with no loss or duplication.
- Abort and reset: producer 1 drops req mid-packet → return to IDLE, rr_ptr = 2. Separately, assert rst_n = 1 mid-burst → fifo_wr_en_o = 0 within the same cycle.
